mips_ifetch_unit: RTL and testbench
===================================

# mips_ifetch_unit

Parametrised instruction-fetch stage for the MIPS pipeline, and the successor of the single-cycle PC/adder/mux fetch path. It owns the PC and issues pipelined requests to instruction memory over a valid/ready handshake. Returned words are buffered in a fetch queue that the decode stage drains with its own valid/ready handshake. EX-stage taken branches and ID-stage jumps redirect the PC, flush the queue, and squash responses still in flight.

## Interface
Parameters:
- XLEN, 32: PC and data width, must be ≥ 32.
- FQ_DEPTH, 4: fetch-queue entries and maximum outstanding requests, power of two, ≥ 2.
- RESET_PC, 0: PC value loaded at reset, must be word aligned.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; in order, one per accepted request, never back-pressured.
- imem_rsp_data  in  32  instruction word.
- if_valid  out  1  queue head valid to decode.
- if_ready  in  1  decode consumes the head.
- if_instr  out  32  head instruction.
- if_pc  out  XLEN  head PC.
- if_pcplus4  out  XLEN  head PC + 4.
- ex_br  in  1  EX branch instruction (Br).
- ex_zero  in  1  EX ALU zero flag.
- ex_pcplus4  in  XLEN  PC + 4 of the branch.
- ex_imm  in  XLEN  sign-extended branch offset in words.
- id_jmp  in  1  ID unconditional jump.
- id_jidx  in  26  jump instruction index field.
- id_pcplus4  in  XLEN  PC + 4 of the jump.

## Operation
- Branch taken when br_take = ex_br & ex_zero. Target = ex_pcplus4 + (ex_imm << 2), modulo 2^XLEN.
- Jump target = {id_pcplus4[XLEN-1:28], id_jidx, 2'b00}.
- redirect = br_take | id_jmp. br_take has priority because the branch is the older instruction; a same-cycle id_jmp is ignored.
- Credit rule: imem_req_valid = !redirect & (fq_count + outstanding < FQ_DEPTH). imem_req_addr = pc.
- Request accept (valid & ready): pc ← pc + 4, outstanding + 1.
- Response: outstanding − 1. If discard > 0, drop the word and decrement discard. Otherwise push {pc_tag, data} into the queue, where pc_tag comes from a FQ_DEPTH-deep tag FIFO of issued addresses.
- Redirect cycle:
  - pc ← target.
  - Queue and tag FIFO flushed.
  - if_valid remains as computed this cycle, but the pop is ignored.
  - discard ← outstanding after this cycle's response is retired, counting any response arriving this cycle as discarded.
- Queue never overflows; guaranteed by the credit rule.
- Pop when if_valid & if_ready.
- Push and pop in the same cycle are allowed when the queue is full (count unchanged) and when it is empty (the word is not bypassed).
- Counters: fq_count, outstanding and discard are each $clog2(FQ_DEPTH+1) bits; read/write pointers wrap at FQ_DEPTH.

## Timing
- Reset values (while rst is low, asynchronously):
  - pc = RESET_PC.
  - All counters and pointers = 0.
  - imem_req_valid = 0, if_valid = 0.
  - imem_req_addr = RESET_PC.
  - if_instr = 0, if_pc = 0, if_pcplus4 = 4.
- First request: imem_req_valid rises in the first clk edge cycle after rst deasserts.
- Latency: a response in cycle N appears on if_valid in cycle N+1.
- Redirect at cycle N:
  - imem_req_valid = 0 in N; this is the only permitted withdrawal of an unaccepted request.
  - First request to target in N+1 if credits allow.
  - Zero-wait memory: the target instruction reaches decode at N+3 at the earliest.
- Throughput: one instruction per cycle sustained with single-cycle memory and if_ready held high.
- Reset asserted mid-operation: all state clears immediately. Responses to requests issued before reset are not tracked; the memory is reset by the same rst.

## Structure
- Package mips_ifetch_pkg:
  - INSTR_W = 32, JIDX_W = 26.
  - Struct fq_entry_t {pc, instr}.
  - Functions br_target() and jmp_target().
- Sub-module mips_ifetch_fifo: generic FQ_DEPTH×width synchronous FIFO with flush, count output and same-cycle push/pop. Instantiated twice: once for the entry queue, once for the PC tag FIFO.

## Test plan
- Reset, always-ready memory with one-cycle response, if_ready = 1 → requests at 0x0, 0x4, 0x8…; if_pc sequence 0x0, 0x4, 0x8 at one per cycle, if_pcplus4 = if_pc + 4.
- Hold if_ready = 0, FQ_DEPTH = 4 → exactly 4 requests accepted, then imem_req_valid = 0; releasing if_ready restores one request per popped entry.
- Branch at ex_pcplus4 = 0x20, ex_imm = 0xFFFFFFFC, ex_zero = 1, with 2 requests outstanding → both responses dropped, queue flushed, next request at 0x10, next if_pc = 0x10.
- id_jmp with id_pcplus4 = 0x1000_0008, id_jidx = 0x0000040, plus br_take in the same cycle → branch target wins; jump alone gives target 0x1000_0100.
- Memory with 3-cycle response latency and random imem_req_ready → in-order if_pc, no duplicates or gaps, outstanding never exceeds FQ_DEPTH.
- rst pulsed low mid-stream with 3 queue entries → if_valid = 0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_ifetch_pkg.sv
// Shared types and target helpers for the MIPS instruction-fetch stage.
package mips_ifetch_pkg;
  localparam int INSTR_W  = 32;
  localparam int JIDX_W   = 26;
  // Widest PC the helpers and the entry struct carry; users truncate to XLEN.
  localparam int XLEN_MAX = 64;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } fq_entry_t;

  function automatic logic [XLEN_MAX-1:0] br_target(input logic [XLEN_MAX-1:0] pcplus4,
                                                    input logic [XLEN_MAX-1:0] imm);
    return pcplus4 + (imm << 2);
  endfunction

  function automatic logic [XLEN_MAX-1:0] jmp_target(input logic [XLEN_MAX-1:0] pcplus4,
                                                     input logic [JIDX_W-1:0]   jidx);
    return (pcplus4 & ~XLEN_MAX'(32'h0FFF_FFFF)) | (XLEN_MAX'(jidx) << 2);
  endfunction
endpackage

// File: rtl/mips_ifetch_fifo.sv
// Synchronous DEPTH x W FIFO with flush, occupancy count and same-cycle push/pop.
module mips_ifetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;

  // Head is read straight from storage; a push is never bypassed to rdata.
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/mips_ifetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited imem requests and
// buffers returned words for decode; branches and jumps redirect and squash.
module mips_ifetch_unit
  import mips_ifetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [XLEN-1:0]    if_pc,
  output logic [XLEN-1:0]    if_pcplus4,
  input  logic               ex_br,
  input  logic               ex_zero,
  input  logic [XLEN-1:0]    ex_pcplus4,
  input  logic [XLEN-1:0]    ex_imm,
  input  logic               id_jmp,
  input  logic [JIDX_W-1:0]  id_jidx,
  input  logic [XLEN-1:0]    id_pcplus4
);
  localparam int          CW      = $clog2(FQ_DEPTH + 1);
  localparam int          EW      = XLEN + INSTR_W;
  localparam logic [CW:0] CREDITS = (CW+1)'(FQ_DEPTH);

  logic [XLEN-1:0] pc, target, tag_head;
  logic [CW-1:0]   fq_count, tag_count, outstanding, discard;
  logic [CW:0]     in_use;
  logic [EW-1:0]   fq_rdata;
  fq_entry_t       head;
  logic            started, br_take, redirect, req_fire, rsp_keep, fq_pop;

  assign br_take  = ex_br & ex_zero;
  assign redirect = br_take | id_jmp;
  assign target   = br_take ? XLEN'(br_target(XLEN_MAX'(ex_pcplus4), XLEN_MAX'(ex_imm)))
                            : XLEN'(jmp_target(XLEN_MAX'(id_pcplus4), id_jidx));

  // Credits cover both queued words and requests still in flight, so the
  // queue can always absorb every response it is going to keep.
  assign in_use         = {1'b0, fq_count} + {1'b0, outstanding};
  assign imem_req_valid = started & ~redirect & (in_use < CREDITS);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_keep = imem_rsp_valid & (discard == '0) & ~redirect & (tag_count != '0);
  assign if_valid = (fq_count != '0);
  assign fq_pop   = if_valid & if_ready & ~redirect;

  mips_ifetch_fifo #(.DEPTH(FQ_DEPTH), .W(XLEN)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (req_fire),
    .wdata (pc),
    .pop   (rsp_keep),
    .rdata (tag_head),
    .count (tag_count)
  );

  mips_ifetch_fifo #(.DEPTH(FQ_DEPTH), .W(EW)) u_entry_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (rsp_keep),
    .wdata ({tag_head, imem_rsp_data}),
    .pop   (fq_pop),
    .rdata (fq_rdata),
    .count (fq_count)
  );

  assign head.pc    = XLEN_MAX'(fq_rdata[INSTR_W +: XLEN]);
  assign head.instr = fq_rdata[INSTR_W-1:0];
  assign if_instr   = head.instr;
  assign if_pc      = XLEN'(head.pc);
  assign if_pcplus4 = if_pc + XLEN'(4);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      started     <= 1'b0;
    end else begin
      started     <= 1'b1;
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect) begin
        pc      <= target;
        // Everything still in flight belongs to the old stream.
        discard <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) pc <= pc + XLEN'(4);
        if (imem_rsp_valid && discard != '0) discard <= discard - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_mips_ifetch_unit.sv
// Randomized bench for mips_ifetch_unit against a stream-level fetch model.
module tb_mips_ifetch_unit;
  localparam int XLEN = 32;
  localparam int D    = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            imem_req_valid, imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            if_valid, if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc, if_pcplus4;
  logic            ex_br, ex_zero, id_jmp;
  logic [XLEN-1:0] ex_pcplus4, ex_imm, id_pcplus4;
  logic [25:0]     id_jidx;

  mips_ifetch_unit #(.XLEN(XLEN), .FQ_DEPTH(D), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc), .if_pcplus4(if_pcplus4),
    .ex_br(ex_br), .ex_zero(ex_zero), .ex_pcplus4(ex_pcplus4), .ex_imm(ex_imm),
    .id_jmp(id_jmp), .id_jidx(id_jidx), .id_pcplus4(id_pcplus4)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] addr; bit stale; } mreq_t;
  mreq_t       mq[$];
  mreq_t       rsp_e;
  bit          rsp_v;
  int          checks, errors, cyc, lat, p_mrdy, p_ifrdy, p_br, p_jmp;
  int          out_m, q_m, n_acc, n_pops, last_pop_cyc, n0, nred;
  logic [31:0] exp_req, exp_if, last_acc, last_pop_pc;
  bit          f_br, f_jmp;
  logic [31:0] f_ex_pc4, f_imm, f_id_pc4;
  logic [25:0] f_jidx;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive at edge+1, check and advance the model at edge+4.
  task automatic cycle();
    bit          redir, pop, push;
    logic [31:0] tgt;
    @(posedge clk); #1;
    cyc++;
    imem_req_ready = ($urandom_range(99) < p_mrdy);
    if_ready       = ($urandom_range(99) < p_ifrdy);
    if (f_br || f_jmp) begin
      ex_br = f_br; ex_zero = 1'b1; ex_pcplus4 = f_ex_pc4; ex_imm = f_imm;
      id_jmp = f_jmp; id_pcplus4 = f_id_pc4; id_jidx = f_jidx;
      f_br = 0; f_jmp = 0;
    end else begin
      ex_br      = ($urandom_range(99) < p_br);
      ex_zero    = 1'($urandom_range(1));
      ex_pcplus4 = $urandom & ~32'h3;
      ex_imm     = 32'($urandom_range(64)) - 32'd32;
      id_jmp     = ($urandom_range(99) < p_jmp);
      id_pcplus4 = $urandom & ~32'h3;
      id_jidx    = 26'($urandom);
    end
    rsp_v = 0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      rsp_e = mq.pop_front();
      rsp_v = 1;
    end
    imem_rsp_valid = rsp_v;
    imem_rsp_data  = rsp_v ? memfn(rsp_e.addr) : $urandom;
    #3;
    redir = (ex_br & ex_zero) | id_jmp;
    tgt   = (ex_br & ex_zero) ? ex_pcplus4 + (ex_imm << 2) : {id_pcplus4[31:28], id_jidx, 2'b00};
    chk("req_valid", imem_req_valid, !redir && (q_m + out_m < D));
    chk("if_valid", if_valid, q_m != 0);
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_req);
      mq.push_back('{due: cyc + lat, addr: imem_req_addr, stale: 1'b0});
      out_m++; n_acc++;
      last_acc = imem_req_addr;
      exp_req += 4;
      chk("outstanding_le_depth", out_m <= D, 1);
    end
    pop = (q_m != 0) && if_ready && !redir;
    if (pop) begin
      chk("if_pc", if_pc, exp_if);
      chk("if_instr", if_instr, memfn(exp_if));
      chk("if_pcplus4", if_pcplus4, exp_if + 4);
      last_pop_pc = if_pc; last_pop_cyc = cyc; n_pops++;
      exp_if += 4;
    end
    push = rsp_v && !rsp_e.stale && !redir;
    if (rsp_v) out_m--;
    q_m = q_m + int'(push) - int'(pop);
    if (redir) begin
      q_m = 0;
      foreach (mq[i]) mq[i].stale = 1;
      exp_req = tgt;
      exp_if  = tgt;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0; if_ready = 0;
    ex_br = 0; ex_zero = 0; ex_pcplus4 = 0; ex_imm = 0;
    id_jmp = 0; id_pcplus4 = 0; id_jidx = 0;
    mq.delete(); out_m = 0; q_m = 0; exp_req = 0; exp_if = 0;
    n_acc = 0; n_pops = 0; f_br = 0; f_jmp = 0;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_instr", if_instr, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_pcplus4", if_pcplus4, 4);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #3 chk("release_req_valid", imem_req_valid, 0);
  endtask

  task automatic wait_pop(input string tag);
    n0 = n_pops;
    for (int i = 0; i < 20 && n_pops == n0; i++) cycle();
    chk(tag, n_pops > n0, 1);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    lat = 1; p_mrdy = 100; p_ifrdy = 100; p_br = 0; p_jmp = 0;
    #2 do_reset();

    // Straight-line fetch, single-cycle memory, decode always ready.
    repeat (4) cycle();
    chk("seq_pops", n_pops, 2);
    chk("seq_last_pc", last_pop_pc, 32'h4);
    n0 = n_pops;
    repeat (16) cycle();
    chk("throughput", n_pops - n0, 16);

    // Decode stalled: credits stop issue after FQ_DEPTH requests.
    do_reset();
    p_ifrdy = 0;
    repeat (12) cycle();
    chk("stall_accepts", n_acc, D);
    chk("stall_req_valid", imem_req_valid, 0);
    p_ifrdy = 100;
    repeat (10) cycle();

    // Taken branch with two responses in flight (3-cycle memory).
    do_reset();
    lat = 3;
    repeat (2) cycle();
    f_br = 1; f_ex_pc4 = 32'h20; f_imm = 32'hFFFF_FFFC;
    cycle();
    chk("br_in_flight", out_m, 2);
    cycle();
    chk("br_next_addr", last_acc, 32'h10);
    wait_pop("br_pop_seen");
    chk("br_if_pc", last_pop_pc, 32'h10);

    // Branch and jump together: branch wins; then jump alone.
    do_reset();
    lat = 1;
    repeat (3) cycle();
    f_br = 1; f_jmp = 1; f_ex_pc4 = 32'h100; f_imm = 32'h4;
    f_id_pc4 = 32'h1000_0008; f_jidx = 26'h40;
    cycle();
    nred = cyc;
    cycle();
    chk("bj_addr", last_acc, 32'h110);
    wait_pop("bj_pop_seen");
    chk("bj_if_pc", last_pop_pc, 32'h110);
    chk("bj_latency", last_pop_cyc - nred, 3);
    f_jmp = 1; f_id_pc4 = 32'h1000_0008; f_jidx = 26'h40;
    cycle();
    cycle();
    chk("jmp_addr", last_acc, 32'h1000_0100);
    wait_pop("jmp_pop_seen");
    chk("jmp_if_pc", last_pop_pc, 32'h1000_0100);

    // Random ready/stall/redirect traffic with 3-cycle memory.
    do_reset();
    lat = 3; p_mrdy = 60; p_ifrdy = 70; p_br = 3; p_jmp = 3;
    repeat (1500) cycle();
    chk("rand_progress", n_pops > 50, 1);

    // Reset pulsed with three entries queued; fetch restarts at RESET_PC.
    lat = 1; p_mrdy = 100; p_br = 0; p_jmp = 0;
    do_reset();
    p_ifrdy = 0;
    for (int i = 0; i < 20 && q_m < 3; i++) cycle();
    chk("mid_q3", q_m, 3);
    chk("mid_if_valid", if_valid, 1);
    do_reset();
    p_ifrdy = 100;
    cycle();
    chk("restart_acc", n_acc, 1);
    chk("restart_addr", last_acc, 32'h0);
    repeat (8) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
